// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator operation sequencer.
//   - one-hot command encodings as delivered by the command interpreter
//   - two-bit operation codes understood by the arithmetic unit
//   - sequencer state encoding
//   - helpers to classify a command and map it to an ALU op code
package calc_pkg;

  localparam logic [3:0] CMD_NONE = 4'b0000;
  localparam logic [3:0] CMD_ADD  = 4'b0001;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_MUL  = 4'b0100;
  localparam logic [3:0] CMD_DIV  = 4'b1000;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;
  localparam logic [1:0] ALU_DIV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ALU = 3'd2,
    ST_CONV     = 3'd3,
    ST_WAIT_BCD = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  // Exactly one bit set: clearing the lowest set bit must leave zero.
  function automatic logic cmd_is_onehot(input logic [3:0] c);
    return (c != CMD_NONE) && ((c & (c - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for one-hot commands; anything else maps to add.
  function automatic logic [1:0] cmd_to_op(input logic [3:0] c);
    logic [1:0] op;
    case (c)
      CMD_SUB: op = ALU_SUB;
      CMD_MUL: op = ALU_MUL;
      CMD_DIV: op = ALU_DIV;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_cmd_slot.sv
// calc_cmd_slot: one-deep pending command register.
//   clk16M   in   system clock
//   rst      in   asynchronous active-low reset (slot empty)
//   load     in   store cmd_in/a_in/b_in if the slot is free (or freed this cycle)
//   take     in   consumer removes the stored command this cycle
//   cmd_in, a_in, b_in   in   command to store
//   full     out  slot holds a command
//   cmd_out, a_out, b_out out stored command
//   ovf      out  one-cycle pulse: a load was refused because the slot was full
module calc_cmd_slot
  import calc_pkg::*;
(
  input  logic       clk16M,
  input  logic       rst,
  input  logic       load,
  input  logic       take,
  input  logic [3:0] cmd_in,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       full,
  output logic [3:0] cmd_out,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic       ovf
);

  logic       full_q, full_d;
  logic [3:0] cmd_q, cmd_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    full_d = full_q;
    cmd_d  = cmd_q;
    a_d    = a_q;
    b_d    = b_q;
    ovf_d  = 1'b0;
    if (take) begin
      full_d = 1'b0;
    end
    // A take in the same cycle frees the slot for the incoming command.
    if (load) begin
      if (!full_q || take) begin
        full_d = 1'b1;
        cmd_d  = cmd_in;
        a_d    = a_in;
        b_d    = b_in;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk16M or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      cmd_q  <= CMD_NONE;
      a_q    <= '0;
      b_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      cmd_q  <= cmd_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ovf_q  <= ovf_d;
    end
  end

  assign full    = full_q;
  assign cmd_out = cmd_q;
  assign a_out   = a_q;
  assign b_out   = b_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/calc_op_ctrl.sv
// calc_op_ctrl: operation sequencer for the calculator datapath.
// Takes operand/command pulses, issues them to the multi-cycle ALU, passes the
// result through the binary-to-BCD converter and presents one registered,
// error-flagged result. One command arriving while busy is buffered, further
// ones are dropped (ovf), and ALU/BCD stalls are aborted after TIMEOUT cycles.
//   clk16M, rst           clock, asynchronous active-low reset
//   cmd_rdy, cmd, op_a/b  command pulse from the interpreter
//   alu_start/op/a/b      issue to ALU;  alu_done/result/err  ALU completion
//   bcd_start/bcd_bin     conversion request;  bcd_done  conversion complete
//   res_valid/res/res_err result pulse and held result
//   busy, ovf             sequencer busy, command-dropped pulse
module calc_op_ctrl
  import calc_pkg::*;
#(
  parameter int BITS    = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk16M,
  input  logic            rst,
  input  logic            cmd_rdy,
  input  logic [3:0]      cmd,
  input  logic [7:0]      op_a,
  input  logic [7:0]      op_b,
  output logic            alu_start,
  output logic [1:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic            alu_done,
  input  logic [BITS-1:0] alu_result,
  input  logic            alu_err,
  output logic            bcd_start,
  output logic [BITS-1:0] bcd_bin,
  input  logic            bcd_done,
  output logic            res_valid,
  output logic [BITS-1:0] res,
  output logic            res_err,
  output logic            busy,
  output logic            ovf
);

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            alu_start_q, alu_start_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic            bcd_start_q, bcd_start_d;
  logic [BITS-1:0] bcd_bin_q, bcd_bin_d;
  logic            res_valid_q, res_valid_d;
  logic [BITS-1:0] res_q, res_d;
  logic            res_err_q, res_err_d;
  logic            busy_q, busy_d;

  logic       new_cmd;
  logic       slot_load, slot_take, slot_full;
  logic [3:0] slot_cmd;
  logic [7:0] slot_a, slot_b;
  logic [3:0] sel_cmd;
  logic [7:0] sel_a, sel_b;
  logic [CW-1:0] cnt_inc;
  logic       cnt_hit;

  assign new_cmd = cmd_rdy && (cmd != CMD_NONE);
  // Only an idle sequencer with an empty slot takes a command directly;
  // everything else (including the FINISH cycle) goes through the slot.
  assign slot_load = new_cmd && !((state_q == ST_IDLE) && !slot_full);
  assign slot_take = (state_q == ST_IDLE) && slot_full;

  // A buffered command always has priority over a fresh one.
  assign sel_cmd = slot_full ? slot_cmd : cmd;
  assign sel_a   = slot_full ? slot_a   : op_a;
  assign sel_b   = slot_full ? slot_b   : op_b;

  // Saturating wait counter; the abort fires on the edge it reaches TIMEOUT,
  // giving res_valid TIMEOUT+1 cycles after entering the wait state.
  assign cnt_inc = (cnt_q == TIMEOUT_V) ? cnt_q : cnt_q + CW'(1);
  assign cnt_hit = (cnt_inc == TIMEOUT_V);

  calc_cmd_slot u_slot (
    .clk16M  (clk16M),
    .rst     (rst),
    .load    (slot_load),
    .take    (slot_take),
    .cmd_in  (cmd),
    .a_in    (op_a),
    .b_in    (op_b),
    .full    (slot_full),
    .cmd_out (slot_cmd),
    .a_out   (slot_a),
    .b_out   (slot_b),
    .ovf     (ovf)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    alu_start_d = 1'b0;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    bcd_start_d = 1'b0;
    bcd_bin_d   = bcd_bin_q;
    res_valid_d = 1'b0;
    res_d       = res_q;
    res_err_d   = res_err_q;

    case (state_q)
      ST_IDLE: begin
        if (slot_full || new_cmd) begin
          if (cmd_is_onehot(sel_cmd)) begin
            alu_op_d = cmd_to_op(sel_cmd);
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            err_d    = 1'b0;
            state_d  = ST_ISSUE;
          end else begin
            // Multi-hot command: never reaches the ALU, reported as error.
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end
      ST_ISSUE: begin
        alu_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_WAIT_ALU;
      end
      ST_WAIT_ALU: begin
        if (alu_done) begin
          bcd_bin_d = alu_result;
          if (alu_err) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_CONV;
          end
        end else if (cnt_hit) begin
          cnt_d   = cnt_inc;
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_CONV: begin
        bcd_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_WAIT_BCD;
      end
      ST_WAIT_BCD: begin
        if (bcd_done) begin
          state_d = ST_FINISH;
        end else if (cnt_hit) begin
          cnt_d   = cnt_inc;
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FINISH: begin
        res_valid_d = 1'b1;
        res_err_d   = err_q;
        res_d       = err_q ? '0 : bcd_bin_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Busy also covers the cycle res_valid is presented.
    busy_d = (state_d != ST_IDLE) || (state_q == ST_FINISH);
  end

  always_ff @(posedge clk16M or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      alu_start_q <= 1'b0;
      alu_op_q    <= ALU_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      bcd_start_q <= 1'b0;
      bcd_bin_q   <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      alu_start_q <= alu_start_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      bcd_start_q <= bcd_start_d;
      bcd_bin_q   <= bcd_bin_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign bcd_start = bcd_start_q;
  assign bcd_bin   = bcd_bin_q;
  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_op_ctrl.sv
// tb_calc_op_ctrl: directed self-checking bench for calc_op_ctrl.
// Main instance uses TIMEOUT=32; a second instance with TIMEOUT=8 covers the
// abort path. Inputs change 1 time unit after the rising edge and outputs are
// sampled at the same point, so "cycle k" is the period after edge k.
module tb_calc_op_ctrl;

  localparam int BITS = 16;

  logic            clk16M = 1'b0;
  logic            rst;
  logic            cmd_rdy, alu_done, alu_err, bcd_done;
  logic [3:0]      cmd;
  logic [7:0]      op_a, op_b;
  logic [BITS-1:0] alu_result;
  logic            alu_start, bcd_start, res_valid, res_err, busy, ovf;
  logic [1:0]      alu_op;
  logic [7:0]      alu_a, alu_b;
  logic [BITS-1:0] bcd_bin, res;

  logic            t_cmd_rdy, t_alu_done, t_alu_err, t_bcd_done;
  logic [3:0]      t_cmd;
  logic [7:0]      t_op_a, t_op_b;
  logic [BITS-1:0] t_alu_result;
  logic            t_alu_start, t_bcd_start, t_res_valid, t_res_err, t_busy, t_ovf;
  logic [1:0]      t_alu_op;
  logic [7:0]      t_alu_a, t_alu_b;
  logic [BITS-1:0] t_bcd_bin, t_res;

  int n_checks = 0;
  int n_pass   = 0;
  int n_alu_start = 0, n_bcd_start = 0, n_res = 0, n_ovf = 0;

  always #5 clk16M = ~clk16M;

  calc_op_ctrl #(.BITS(BITS), .TIMEOUT(32)) u_dut (
    .clk16M(clk16M), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .op_a(op_a), .op_b(op_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .bcd_start(bcd_start), .bcd_bin(bcd_bin), .bcd_done(bcd_done),
    .res_valid(res_valid), .res(res), .res_err(res_err), .busy(busy), .ovf(ovf)
  );

  calc_op_ctrl #(.BITS(BITS), .TIMEOUT(8)) u_dut_to (
    .clk16M(clk16M), .rst(rst), .cmd_rdy(t_cmd_rdy), .cmd(t_cmd), .op_a(t_op_a), .op_b(t_op_b),
    .alu_start(t_alu_start), .alu_op(t_alu_op), .alu_a(t_alu_a), .alu_b(t_alu_b),
    .alu_done(t_alu_done), .alu_result(t_alu_result), .alu_err(t_alu_err),
    .bcd_start(t_bcd_start), .bcd_bin(t_bcd_bin), .bcd_done(t_bcd_done),
    .res_valid(t_res_valid), .res(t_res), .res_err(t_res_err), .busy(t_busy), .ovf(t_ovf)
  );

  // Pulse counters for the main instance, sampled mid-cycle.
  always @(negedge clk16M) begin
    if (alu_start) n_alu_start <= n_alu_start + 1;
    if (bcd_start) n_bcd_start <= n_bcd_start + 1;
    if (res_valid) n_res       <= n_res + 1;
    if (ovf)       n_ovf       <= n_ovf + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk16M);
    #1;
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      0: return alu_start;
      1: return bcd_start;
      2: return res_valid;
      3: return t_alu_start;
      4: return t_bcd_start;
      default: return t_res_valid;
    endcase
  endfunction

  // Bounded wait for a DUT pulse; an expired bound is a failed comparison.
  task automatic wait_sig(input int sel, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      seen = sig_sel(sel);
      if (seen) break;
      tick();
    end
    if (!seen) check(tag, 32'(seen), 1);
  endtask

  task automatic send(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    cmd_rdy = 1'b1; cmd = c; op_a = a; op_b = b;
    tick();
    cmd_rdy = 1'b0; cmd = 4'b0000;
  endtask

  // Called while the DUT sits in WAIT_ALU; answers ALU and BCD immediately.
  task automatic finish_op(input logic [15:0] r, input logic e);
    alu_done = 1'b1; alu_result = r; alu_err = e;
    tick();
    alu_done = 1'b0; alu_err = 1'b0;
    if (!e) begin
      wait_sig(1, "wait_bcd_start");
      bcd_done = 1'b1;
      tick();
      bcd_done = 1'b0;
    end
    wait_sig(2, "wait_res_valid");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_alu, base_bcd, base_res, base_ovf, n;
    rst = 1'b0;
    cmd_rdy = 0; cmd = 0; op_a = 0; op_b = 0; alu_done = 0; alu_err = 0; alu_result = 0; bcd_done = 0;
    t_cmd_rdy = 0; t_cmd = 0; t_op_a = 0; t_op_b = 0; t_alu_done = 0; t_alu_err = 0;
    t_alu_result = 0; t_bcd_done = 0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_res", res, 0);
    check("rst_res_err", res_err, 0);
    check("rst_pulses", {alu_start, bcd_start, res_valid, ovf}, 0);
    check("rst_alu_regs", {alu_op, alu_a, alu_b}, 0);
    check("rst_bcd_bin", bcd_bin, 0);
    rst = 1'b1;
    tick();

    // Add 25+17 with zero-wait ALU/BCD and exact cycle latency.
    base_alu = n_alu_start; base_bcd = n_bcd_start;
    send(4'b0001, 8'd25, 8'd17);
    check("add_busy_rise", busy, 1);
    tick();
    check("add_alu_start_c1", alu_start, 1);
    check("add_alu_op", alu_op, 0);
    check("add_alu_ab", {alu_a, alu_b}, {8'd25, 8'd17});
    alu_done = 1; alu_result = 16'd42;
    tick();
    alu_done = 0;
    check("add_alu_start_1cyc", alu_start, 0);
    tick();
    check("add_bcd_start_c3", bcd_start, 1);
    check("add_bcd_bin", bcd_bin, 42);
    bcd_done = 1;
    tick();
    bcd_done = 0;
    check("add_no_early_res", res_valid, 0);
    tick();
    check("add_res_valid_c5", res_valid, 1);
    check("add_res", res, 42);
    check("add_res_err", res_err, 0);
    check("add_busy_in_res", busy, 1);
    $display("txn add 25+17: res=%0d err=%0d", res, res_err);
    tick();
    check("add_res_valid_1cyc", res_valid, 0);
    check("add_busy_fall", busy, 0);
    check("add_res_held", res, 42);
    check("add_alu_starts", n_alu_start - base_alu, 1);
    check("add_bcd_starts", n_bcd_start - base_bcd, 1);

    // Divide by zero: error path, two cycles from alu_done to res_valid.
    base_bcd = n_bcd_start;
    send(4'b1000, 8'd9, 8'd0);
    tick();
    check("div_alu_start", alu_start, 1);
    check("div_alu_op", alu_op, 3);
    alu_done = 1; alu_err = 1; alu_result = 16'hFFFF;
    tick();
    alu_done = 0; alu_err = 0;
    check("div_no_res_yet", res_valid, 0);
    tick();
    check("div_res_valid", res_valid, 1);
    check("div_res", res, 0);
    check("div_res_err", res_err, 1);
    check("div_no_bcd", n_bcd_start - base_bcd, 0);
    $display("txn div 9/0: res=%0d err=%0d", res, res_err);
    tick();

    // Back-to-back: second buffered, third dropped, results in order.
    base_alu = n_alu_start; base_res = n_res; base_ovf = n_ovf;
    send(4'b0001, 8'd1, 8'd2);
    tick();
    check("b2b_alu_start", alu_start, 1);
    send(4'b0010, 8'd10, 8'd3);
    send(4'b0100, 8'd4, 8'd5);
    check("b2b_ovf_pulse", ovf, 1);
    tick();
    check("b2b_ovf_1cyc", ovf, 0);
    repeat (16) tick();
    check("b2b_still_busy", busy, 1);
    finish_op(16'd3, 1'b0);
    check("b2b_res1", res, 3);
    check("b2b_err1", res_err, 0);
    $display("txn b2b first 1+2: res=%0d err=%0d", res, res_err);
    wait_sig(0, "wait_b2b_alu_start2");
    check("b2b_op2", alu_op, 1);
    check("b2b_ab2", {alu_a, alu_b}, {8'd10, 8'd3});
    finish_op(16'd7, 1'b0);
    check("b2b_res2", res, 7);
    $display("txn b2b second 10-3: res=%0d err=%0d", res, res_err);
    tick();
    check("b2b_busy_fall", busy, 0);
    repeat (3) tick();
    check("b2b_alu_starts", n_alu_start - base_alu, 2);
    check("b2b_res_count", n_res - base_res, 2);
    check("b2b_ovf_count", n_ovf - base_ovf, 1);

    // Multi-hot command: error result without touching the ALU.
    base_alu = n_alu_start; base_res = n_res;
    send(4'b0110, 8'd1, 8'd2);
    check("ill_busy", busy, 1);
    tick();
    check("ill_res_valid", res_valid, 1);
    check("ill_res_err", res_err, 1);
    check("ill_res", res, 0);
    $display("txn illegal 0110: res=%0d err=%0d", res, res_err);
    tick();
    check("ill_busy_fall", busy, 0);
    check("ill_no_alu", n_alu_start - base_alu, 0);

    // cmd 0000 is ignored.
    base_res = n_res;
    send(4'b0000, 8'd5, 8'd5);
    check("none_busy0", busy, 0);
    tick(); tick();
    check("none_busy1", busy, 0);
    check("none_no_res", n_res - base_res, 0);
    $display("txn none 0000: busy=%0d", busy);

    // Timeout on the TIMEOUT=8 instance, then a normal command.
    t_cmd_rdy = 1; t_cmd = 4'b0001; t_op_a = 8'd3; t_op_b = 8'd4;
    tick();
    t_cmd_rdy = 0; t_cmd = 0;
    tick();
    check("to_alu_start", t_alu_start, 1);
    n = 0;
    while (!t_res_valid && n < 40) begin
      tick();
      n++;
    end
    check("to_latency", n, 9);
    check("to_res_err", t_res_err, 1);
    check("to_res", t_res, 0);
    $display("txn timeout: cycles=%0d res=%0d err=%0d", n, t_res, t_res_err);
    tick();
    t_cmd_rdy = 1; t_cmd = 4'b0001; t_op_a = 8'd3; t_op_b = 8'd4;
    tick();
    t_cmd_rdy = 0; t_cmd = 0;
    wait_sig(3, "wait_to_alu_start");
    t_alu_done = 1; t_alu_result = 16'd7;
    tick();
    t_alu_done = 0;
    wait_sig(4, "wait_to_bcd_start");
    t_bcd_done = 1;
    tick();
    t_bcd_done = 0;
    wait_sig(5, "wait_to_res_valid");
    check("to_next_res", t_res, 7);
    check("to_next_err", t_res_err, 0);
    $display("txn after timeout 3+4: res=%0d err=%0d", t_res, t_res_err);
    tick();

    // Reset during WAIT_BCD with the slot full.
    send(4'b0001, 8'd5, 8'd6);
    wait_sig(0, "wait_rst_alu_start");
    cmd_rdy = 1; cmd = 4'b0010; op_a = 8'd1; op_b = 8'd1;
    alu_done = 1; alu_result = 16'd11;
    tick();
    cmd_rdy = 0; cmd = 0; alu_done = 0;
    wait_sig(1, "wait_rst_bcd_start");
    tick();
    base_alu = n_alu_start; base_res = n_res;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_bcd_bin", bcd_bin, 0);
    check("mid_rst_res", res, 0);
    check("mid_rst_alu_regs", {alu_op, alu_a, alu_b}, 0);
    check("mid_rst_pulses", {alu_start, bcd_start, res_valid, ovf}, 0);
    tick(); tick();
    rst = 1'b1;
    bcd_done = 1;
    tick();
    bcd_done = 0;
    repeat (10) tick();
    check("mid_rst_no_res", n_res - base_res, 0);
    check("mid_rst_slot_empty", n_alu_start - base_alu, 0);
    check("mid_rst_idle", busy, 0);
    $display("txn reset mid-op: busy=%0d res=%0d", busy, res);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
